// File: rtl/tl_fifo_wr_arbiter.sv
// Round-robin write-port arbiter feeding the write side of a dual-clock FIFO.
// The grant is locked for a whole burst, so bursts are never interleaved in the FIFO.
module tl_fifo_wr_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BEATS  = 8
) (
  input  logic                             clk,
  input  logic                             reset_n,
  input  logic [NUM_REQ-1:0]               req_valid,
  input  logic [NUM_REQ-1:0]               req_last,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_data,
  output logic [NUM_REQ-1:0]               req_ready,
  output logic                             fifo_wr_en,
  output logic [DATA_WIDTH-1:0]            fifo_wr_data,
  input  logic                             fifo_full,
  output logic                             grant_valid,
  output logic [$clog2(NUM_REQ)-1:0]       grant_id,
  output logic                             burst_err
);

  localparam int ID_W  = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(MAX_BEATS + 1);

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t          state;
  logic [ID_W-1:0] rr_ptr;
  logic [ID_W-1:0] owner;
  logic [CNT_W-1:0] beat_cnt;
  logic [ID_W-1:0] winner;
  logic            found;
  logic [ID_W-1:0] next_ptr;
  logic            cut;

  // Wraps at NUM_REQ rather than 2**ID_W so non-power-of-2 counts rotate correctly.
  function automatic logic [ID_W-1:0] inc_id(input logic [ID_W-1:0] id);
    return (id == ID_W'(NUM_REQ - 1)) ? '0 : id + 1'b1;
  endfunction

  // Scanning from the farthest offset down lets the nearest valid requester win.
  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (req_valid[ID_W'((int'(rr_ptr) + k) % NUM_REQ)]) begin
        winner = ID_W'((int'(rr_ptr) + k) % NUM_REQ);
        found  = 1'b1;
      end
    end
  end

  // Outputs are forced low while reset is asserted, even though they are combinational.
  always_comb begin
    grant_valid = 1'b0;
    grant_id    = '0;
    if (reset_n) begin
      if (state == LOCKED) begin
        grant_valid = 1'b1;
        grant_id    = owner;
      end else if (found) begin
        grant_valid = 1'b1;
        grant_id    = winner;
      end
    end
  end

  assign fifo_wr_en   = grant_valid && req_valid[grant_id] && !fifo_full;
  assign fifo_wr_data = grant_valid ? req_data[int'(grant_id)*DATA_WIDTH +: DATA_WIDTH]
                                    : '0;

  always_comb begin
    req_ready = '0;
    if (fifo_wr_en) req_ready[grant_id] = 1'b1;
  end

  assign next_ptr = inc_id(grant_id);
  // beat_cnt is zero in IDLE, so the same test covers MAX_BEATS=1 single-beat cuts.
  assign cut      = (int'(beat_cnt) + 1 == MAX_BEATS);

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      owner     <= '0;
      beat_cnt  <= '0;
      burst_err <= 1'b0;
    end else begin
      burst_err <= 1'b0;
      if (fifo_wr_en) begin
        if (req_last[grant_id]) begin
          state    <= IDLE;
          rr_ptr   <= next_ptr;
          beat_cnt <= '0;
        end else if (cut) begin
          state     <= IDLE;
          rr_ptr    <= next_ptr;
          beat_cnt  <= '0;
          burst_err <= 1'b1;
        end else begin
          state    <= LOCKED;
          owner    <= grant_id;
          beat_cnt <= beat_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_tl_fifo_wr_arbiter.sv
// Directed bench for tl_fifo_wr_arbiter: round-robin order, burst locking, backpressure,
// MAX_BEATS cut, owner stall and asynchronous reset during a lock.
module tb_tl_fifo_wr_arbiter;

  localparam int NUM_REQ    = 4;
  localparam int DATA_WIDTH = 8;
  localparam int MAX_BEATS  = 8;

  logic                          clk = 1'b0;
  logic                          reset_n;
  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ-1:0]            req_last;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]            req_ready;
  logic                          fifo_wr_en;
  logic [DATA_WIDTH-1:0]         fifo_wr_data;
  logic                          fifo_full;
  logic                          grant_valid;
  logic [1:0]                    grant_id;
  logic                          burst_err;

  int n_checks = 0;
  int n_fail   = 0;

  tl_fifo_wr_arbiter #(
    .NUM_REQ(NUM_REQ), .DATA_WIDTH(DATA_WIDTH), .MAX_BEATS(MAX_BEATS)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_last(req_last), .req_data(req_data),
    .req_ready(req_ready),
    .fifo_wr_en(fifo_wr_en), .fifo_wr_data(fifo_wr_data), .fifo_full(fifo_full),
    .grant_valid(grant_valid), .grant_id(grant_id), .burst_err(burst_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Checks all combinational outputs at once; ready is derived from the expected grant.
  task automatic check_out(input string tag, input logic gv, input logic [1:0] gid,
                           input logic we, input logic [7:0] data);
    logic [3:0] rdy;
    rdy = we ? (4'b0001 << gid) : 4'b0000;
    check({tag, ".grant_valid"}, grant_valid, gv);
    check({tag, ".grant_id"},    grant_id,    gid);
    check({tag, ".wr_en"},       fifo_wr_en,  we);
    check({tag, ".ready"},       req_ready,   rdy);
    check({tag, ".wr_data"},     fifo_wr_data, data);
  endtask

  task automatic drive(input int i, input logic v, input logic l, input logic [7:0] d);
    req_valid[i] = v;
    req_last[i]  = l;
    req_data[i*DATA_WIDTH +: DATA_WIDTH] = d;
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [1:0] rr_seq [5];
    rr_seq = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};

    // Reset: all outputs held low even with every requester valid.
    reset_n   = 1'b0;
    fifo_full = 1'b0;
    req_valid = '0;
    req_last  = '0;
    req_data  = '0;
    for (int i = 0; i < NUM_REQ; i++) drive(i, 1'b1, 1'b1, 8'(8'h10 + i));
    #3;
    check_out("reset", 1'b0, 2'd0, 1'b0, 8'h00);
    check("reset.burst_err", burst_err, 1'b0);

    // Single-beat packets from all four: grants rotate 0,1,2,3,0.
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    for (int k = 0; k < 5; k++) begin
      check_out($sformatf("rr%0d", k), 1'b1, rr_seq[k], 1'b1, 8'(8'h10 + rr_seq[k]));
      cycle();
    end

    // rr_ptr=1. Requester 2 bursts A,B,C while requester 0 waits.
    drive(1, 1'b0, 1'b1, 8'h00);
    drive(3, 1'b0, 1'b1, 8'h00);
    drive(0, 1'b1, 1'b1, 8'h55);
    drive(2, 1'b1, 1'b0, 8'hA0);
    #1; check_out("burstA", 1'b1, 2'd2, 1'b1, 8'hA0);
    cycle();
    drive(2, 1'b1, 1'b0, 8'hB0);
    #1; check_out("burstB", 1'b1, 2'd2, 1'b1, 8'hB0);
    cycle();
    drive(2, 1'b1, 1'b1, 8'hC0);
    #1; check_out("burstC", 1'b1, 2'd2, 1'b1, 8'hC0);
    cycle();
    // rr_ptr must now be 3: requester 2 is valid again but 0 comes first from 3.
    drive(2, 1'b1, 1'b1, 8'hD0);
    #1; check_out("after_burst", 1'b1, 2'd0, 1'b1, 8'h55);
    cycle();
    req_valid = '0;
    #1; check_out("no_req", 1'b0, 2'd0, 1'b0, 8'h00);

    // rr_ptr=1. Requester 1 burst stalled two cycles by fifo_full.
    drive(1, 1'b1, 1'b0, 8'h31);
    drive(2, 1'b1, 1'b1, 8'h22);
    drive(3, 1'b1, 1'b1, 8'h33);
    #1; check_out("full_b1", 1'b1, 2'd1, 1'b1, 8'h31);
    cycle();
    drive(1, 1'b1, 1'b0, 8'h32);
    fifo_full = 1'b1;
    #1; check_out("full_s1", 1'b1, 2'd1, 1'b0, 8'h32);
    cycle();
    #1; check_out("full_s2", 1'b1, 2'd1, 1'b0, 8'h32);
    cycle();
    fifo_full = 1'b0;
    #1; check_out("full_b2", 1'b1, 2'd1, 1'b1, 8'h32);
    cycle();
    drive(1, 1'b1, 1'b1, 8'h33);
    #1; check_out("full_b3", 1'b1, 2'd1, 1'b1, 8'h33);
    cycle();

    // rr_ptr=2. Requester 3 sends 10 beats without last; cut after 8.
    req_valid = '0;
    drive(0, 1'b1, 1'b1, 8'h05);
    for (int k = 0; k < 8; k++) begin
      drive(3, 1'b1, 1'b0, 8'(8'h80 + k));
      #1;
      check_out($sformatf("long%0d", k), 1'b1, 2'd3, 1'b1, 8'(8'h80 + k));
      check($sformatf("long%0d.burst_err", k), burst_err, 1'b0);
      cycle();
    end
    drive(3, 1'b1, 1'b0, 8'h88);
    #1;
    check("cut.burst_err", burst_err, 1'b1);
    check_out("cut_next", 1'b1, 2'd0, 1'b1, 8'h05);
    cycle();
    check("cut.burst_err_drop", burst_err, 1'b0);
    drive(0, 1'b0, 1'b1, 8'h00);
    #1; check_out("rem0", 1'b1, 2'd3, 1'b1, 8'h88);
    cycle();
    drive(3, 1'b1, 1'b1, 8'h89);
    #1; check_out("rem1", 1'b1, 2'd3, 1'b1, 8'h89);
    cycle();
    check("rem.burst_err", burst_err, 1'b0);

    // rr_ptr=0. Owner 0 drops valid for 3 cycles mid-burst; others ignored.
    req_valid = '0;
    drive(0, 1'b1, 1'b0, 8'hA0);
    drive(1, 1'b1, 1'b1, 8'h11);
    drive(2, 1'b1, 1'b1, 8'h22);
    #1; check_out("stall_b1", 1'b1, 2'd0, 1'b1, 8'hA0);
    cycle();
    drive(0, 1'b0, 1'b0, 8'hEE);
    for (int k = 0; k < 3; k++) begin
      #1; check_out($sformatf("stall%0d", k), 1'b1, 2'd0, 1'b0, 8'hEE);
      cycle();
    end
    drive(0, 1'b1, 1'b1, 8'hA1);
    #1; check_out("stall_b2", 1'b1, 2'd0, 1'b1, 8'hA1);
    cycle();
    #1; check_out("stall_next", 1'b1, 2'd1, 1'b1, 8'h11);

    // rr_ptr=1. Lock requester 1, then reset asynchronously mid-burst.
    drive(1, 1'b1, 1'b0, 8'h41);
    cycle();
    for (int i = 0; i < NUM_REQ; i++) drive(i, 1'b1, 1'b1, 8'(8'h60 + i));
    drive(1, 1'b1, 1'b0, 8'h61);
    #1; check_out("pre_reset", 1'b1, 2'd1, 1'b1, 8'h61);
    #1;
    reset_n = 1'b0;
    #1; check_out("async_reset", 1'b0, 2'd0, 1'b0, 8'h00);
    check("async_reset.burst_err", burst_err, 1'b0);
    cycle();
    #2;
    reset_n = 1'b1;
    #1; check_out("post_reset", 1'b1, 2'd0, 1'b1, 8'h60);
    cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
